// File: rtl/lstm_seq_ctrl.sv
// Sequencing controller for one lstm cell: serial weight/bias load, then one-sample-at-a-time
// stepping with initial h/C injection on sequence start and a per-step timeout watchdog.
module lstm_seq_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_sel,
  input  logic [1:0]         cfg_gate,
  input  logic [WIDTH-1:0]   cfg_data,
  input  logic               s_x_valid,
  output logic               s_x_ready,
  input  logic [WIDTH-1:0]   s_x_data,
  input  logic               s_x_first,
  input  logic               s_x_last,
  input  logic [WIDTH-1:0]   s_h_init,
  input  logic [WIDTH-1:0]   s_c_init,
  output logic               m_y_valid,
  input  logic               m_y_ready,
  output logic [WIDTH-1:0]   m_y_data,
  output logic [WIDTH-1:0]   m_c_data,
  output logic               m_y_last,
  input  logic               lstm_ready,
  output logic [4*WIDTH-1:0] lstm_weight_x,
  output logic [4*WIDTH-1:0] lstm_weight_h,
  output logic [4*WIDTH-1:0] lstm_bias_x,
  output logic [4*WIDTH-1:0] lstm_bias_h,
  output logic [3:0]         lstm_weight_x_valid,
  output logic [3:0]         lstm_weight_h_valid,
  output logic [3:0]         lstm_bias_x_valid,
  output logic [3:0]         lstm_bias_h_valid,
  output logic [WIDTH-1:0]   lstm_x_in,
  output logic [WIDTH-1:0]   lstm_h_in,
  output logic [WIDTH-1:0]   lstm_c_in,
  output logic               lstm_x_in_valid,
  output logic               lstm_h_in_valid,
  output logic               lstm_c_in_valid,
  input  logic [WIDTH-1:0]   lstm_y_out,
  input  logic [WIDTH-1:0]   lstm_c_out,
  input  logic               lstm_valid,
  output logic               busy,
  output logic [LEN_W-1:0]   seq_count,
  output logic [1:0]         err,
  input  logic               err_clr
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StCfg, StIssue, StWait} state_e;

  state_e             state_q, state_d;
  logic               run_q;
  logic [4*WIDTH-1:0] wx_q, wx_d, wh_q, wh_d, bx_q, bx_d, bh_q, bh_d;
  logic [3:0]         wx_v_q, wx_v_d, wh_v_q, wh_v_d, bx_v_q, bx_v_d, bh_v_q, bh_v_d;
  logic [WIDTH-1:0]   x_q, x_d, h_q, h_d, c_q, c_d;
  logic               x_v_q, x_v_d, h_v_q, h_v_d, c_v_q, c_v_d;
  logic               last_q, last_d;
  logic [WIDTH-1:0]   y_q, y_d, yc_q, yc_d;
  logic               ylast_q, ylast_d, yv_q, yv_d;
  logic [LEN_W-1:0]   seq_q, seq_d;
  logic [1:0]         err_q, err_d, err_set;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic               cfg_fire, x_fire;
  logic [3:0]         gate_oh;

  // run_q keeps both ready outputs low while reset is held and for the first cycle after
  assign cfg_ready = run_q && (state_q == StIdle) && lstm_ready;
  assign s_x_ready = run_q && (state_q == StIdle) && lstm_ready && !cfg_valid &&
                     (!yv_q || m_y_ready);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign x_fire    = s_x_valid && s_x_ready;
  assign gate_oh   = 4'b0001 << cfg_gate;

  always_comb begin
    state_d = state_q;
    wx_d = wx_q;  wh_d = wh_q;  bx_d = bx_q;  bh_d = bh_q;
    wx_v_d = '0;  wh_v_d = '0;  bx_v_d = '0;  bh_v_d = '0;
    x_d = x_q;  h_d = h_q;  c_d = c_q;
    x_v_d = 1'b0;  h_v_d = 1'b0;  c_v_d = 1'b0;
    last_d = last_q;
    y_d = y_q;  yc_d = yc_q;  ylast_d = ylast_q;  yv_d = yv_q;
    seq_d = seq_q;
    cnt_d = cnt_q;
    err_set = '0;

    if (yv_q && m_y_ready) yv_d = 1'b0;
    if (lstm_valid && (state_q != StWait)) err_set[1] = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (cfg_fire) begin
          state_d = StCfg;
          unique case (cfg_sel)
            2'd0: begin wx_d = {4{cfg_data}}; wx_v_d = gate_oh; end
            2'd1: begin wh_d = {4{cfg_data}}; wh_v_d = gate_oh; end
            2'd2: begin bx_d = {4{cfg_data}}; bx_v_d = gate_oh; end
            default: begin bh_d = {4{cfg_data}}; bh_v_d = gate_oh; end
          endcase
        end else if (x_fire) begin
          state_d = StIssue;
          x_d     = s_x_data;
          x_v_d   = 1'b1;
          h_v_d   = s_x_first;
          c_v_d   = s_x_first;
          last_d  = s_x_last;
          if (s_x_first) begin
            h_d   = s_h_init;
            c_d   = s_c_init;
            seq_d = LEN_W'(1);
          end else if (seq_q != '1) begin
            seq_d = seq_q + LEN_W'(1);
          end
        end
      end
      StCfg: state_d = StIdle;
      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (lstm_valid) begin
          state_d = StIdle;
          y_d     = lstm_y_out;
          yc_d    = lstm_c_out;
          ylast_d = last_q;
          yv_d    = 1'b1;
        end else if (cnt_q == TLast) begin
          state_d    = StIdle;
          err_set[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // a set event in the same cycle beats the clear
    err_d = (err_clr ? 2'b00 : err_q) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      run_q   <= 1'b0;
      wx_q <= '0;  wh_q <= '0;  bx_q <= '0;  bh_q <= '0;
      wx_v_q <= '0;  wh_v_q <= '0;  bx_v_q <= '0;  bh_v_q <= '0;
      x_q <= '0;  h_q <= '0;  c_q <= '0;
      x_v_q <= 1'b0;  h_v_q <= 1'b0;  c_v_q <= 1'b0;
      last_q  <= 1'b0;
      y_q <= '0;  yc_q <= '0;  ylast_q <= 1'b0;  yv_q <= 1'b0;
      seq_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      wx_q <= wx_d;  wh_q <= wh_d;  bx_q <= bx_d;  bh_q <= bh_d;
      wx_v_q <= wx_v_d;  wh_v_q <= wh_v_d;  bx_v_q <= bx_v_d;  bh_v_q <= bh_v_d;
      x_q <= x_d;  h_q <= h_d;  c_q <= c_d;
      x_v_q <= x_v_d;  h_v_q <= h_v_d;  c_v_q <= c_v_d;
      last_q  <= last_d;
      y_q <= y_d;  yc_q <= yc_d;  ylast_q <= ylast_d;  yv_q <= yv_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_y_valid           = yv_q;
  assign m_y_data            = y_q;
  assign m_c_data            = yc_q;
  assign m_y_last            = ylast_q;
  assign lstm_weight_x       = wx_q;
  assign lstm_weight_h       = wh_q;
  assign lstm_bias_x         = bx_q;
  assign lstm_bias_h         = bh_q;
  assign lstm_weight_x_valid = wx_v_q;
  assign lstm_weight_h_valid = wh_v_q;
  assign lstm_bias_x_valid   = bx_v_q;
  assign lstm_bias_h_valid   = bh_v_q;
  assign lstm_x_in           = x_q;
  assign lstm_h_in           = h_q;
  assign lstm_c_in           = c_q;
  assign lstm_x_in_valid     = x_v_q;
  assign lstm_h_in_valid     = h_v_q;
  assign lstm_c_in_valid     = c_v_q;
  assign busy                = (state_q != StIdle) || yv_q;
  assign seq_count           = seq_q;
  assign err                 = err_q;

endmodule

// File: doc/lstm_seq_ctrl.md
# lstm_seq_ctrl

Sequencing controller placed in front of one `lstm` cell instance. It loads the cell's per-gate weights and biases from a serial config stream, then steps the cell through input sequences one sample at a time. On the first sample of each sequence it injects the initial h/C state, and for later samples it leaves the cell's internal h/C feedback in place. Each step's y/C result goes out on a backpressured stream, with a timeout watchdog on every step.

## Interface
- `WIDTH`, 16, datapath and weight width (Q8.8 signed)
- `LEN_W`, 8, width of the sequence step counter
- `TIMEOUT`, 15, max cycles in WAIT without `lstm_valid` before abort
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `cfg_valid` / `cfg_ready`  in/out  1  config beat handshake
- `cfg_sel`  in  2  target: 0 weight_x, 1 weight_h, 2 bias_x, 3 bias_h
- `cfg_gate`  in  2  gate lane: 0 i, 1 f, 2 g, 3 o
- `cfg_data`  in  WIDTH  value
- `s_x_valid` / `s_x_ready`  in/out  1  input sample handshake
- `s_x_data`  in  WIDTH  sample x
- `s_x_first`, `s_x_last`  in  1  sequence start / end markers
- `s_h_init`, `s_c_init`  in  WIDTH  initial h/C; used only when `s_x_first`
- `m_y_valid` / `m_y_ready`  out/in  1  result handshake
- `m_y_data`, `m_c_data`  out  WIDTH  step y and C
- `m_y_last`  out  1  copy of the step's `s_x_last`
- `lstm_ready`  in  1  cell ready
- `lstm_weight_x`, `lstm_weight_h`, `lstm_bias_x`, `lstm_bias_h`  out  4×WIDTH  cell config lanes
- `lstm_weight_x_valid`, `lstm_weight_h_valid`, `lstm_bias_x_valid`, `lstm_bias_h_valid`  out  4  per-lane write strobes
- `lstm_x_in`, `lstm_h_in`, `lstm_c_in`  out  WIDTH  cell data
- `lstm_x_in_valid`, `lstm_h_in_valid`, `lstm_c_in_valid`  out  1  cell data strobes
- `lstm_y_out`, `lstm_c_out`, `lstm_valid`  in  cell result
- `busy`  out  1  state ≠ IDLE or `m_y_valid`
- `seq_count`  out  LEN_W  steps accepted in the current sequence
- `err`  out  2  sticky: [0] timeout, [1] spurious `lstm_valid`
- `err_clr`  in  1  synchronous clear of `err`

## Operation
- **States:** IDLE, CFG, ISSUE, WAIT. All `lstm_*` outputs are registered.
- **IDLE, config has priority.** `cfg_ready = IDLE && lstm_ready`.
  - On accept: latch the beat and go to CFG.
- **IDLE, sample accept.** `s_x_ready = IDLE && lstm_ready && !cfg_valid && (!m_y_valid || m_y_ready)`.
  - On accept: latch x, first, last, h_init, c_init and go to ISSUE.
- **CFG, 1 cycle.**
  - `cfg_data` is broadcast on all four lanes of the selected bus.
  - Only the strobe bit `cfg_gate` of bus `cfg_sel` is high.
  - Return to IDLE.
- **ISSUE, 1 cycle.**
  - `lstm_x_in_valid = 1`.
  - `lstm_h_in_valid = lstm_c_in_valid = first`, with `lstm_h_in = h_init` and `lstm_c_in = c_init`.
  - Go to WAIT and clear the timeout counter.
- **WAIT.**
  - On `lstm_valid`: capture `lstm_y_out` / `lstm_c_out` and `last` into the output register, set `m_y_valid`, go to IDLE.
  - If the counter reaches TIMEOUT: set `err[0]`, go to IDLE, produce no output.
- **Output register.** `m_y_valid` holds until `m_y_ready`; the data is stable while valid and not yet accepted.
- **seq_count.**
  - Set to 1 on accepting a first-flagged sample.
  - Otherwise +1 per accepted sample, saturating at all-ones.
- **Spurious result.** `lstm_valid` outside WAIT sets `err[1]` and is otherwise ignored.
- **err.** `err_clr` clears `err`; a set event in the same cycle wins.
- **Simultaneous inputs.** `cfg_valid` and `s_x_valid` both high in IDLE: the config beat is taken, and the sample waits.

## Timing
- **Reset values:** all outputs 0, state IDLE.
- **Async reset.** `rst_n` low clears the state immediately.
  - An in-flight step is dropped.
  - A pending result is discarded (`m_y_valid` → 0).
- **Config write.** Accept at cycle N, strobe at N+1. The next beat can be accepted at N+2, so throughput is 1 beat per 2 cycles.
- **Sample step.** Accept at N, `lstm_x_in_valid` at N+1.
  - With the 7-stage cell, `lstm_valid` arrives at N+8 and `m_y_valid` rises at N+9.
  - `s_x_ready` can rise again at N+9 at the earliest.
- **Strobes.** Every strobe is exactly one cycle wide. Data outputs hold their last value otherwise.

## Test plan
- **Config load.** Send 16 beats covering every (sel, gate) pair, value `0x0100+8*sel+gate`.
  - Each beat produces exactly one strobe at N+1, on the right bit, with the value on that lane.
  - `cfg_ready` toggles 1,0.
- **Single step.** Identity-ish weights; x=0x0100, first=last=1, h_init=c_init=0.
  - `lstm_h_in_valid` and `lstm_c_in_valid` pulse together with `lstm_x_in_valid` at N+1.
  - `m_y_valid` at N+9, `m_y_last=1`, `seq_count=1`.
- **Sequence of 4.** Only sample 0 drives the h/C strobes.
  - `seq_count` runs 1..4.
  - `m_y_last` is set only on result 4.
  - With `m_y_ready` tied high, results are spaced 9 cycles apart.
- **Backpressure.** Hold `m_y_ready=0` for 20 cycles after the first result.
  - `s_x_ready` stays 0 and the data stays stable.
  - Release: the result transfers and the next sample is accepted the same cycle.
- **Timeout and spurious valid.** Model a cell that never asserts valid.
  - Return to IDLE after 15 WAIT cycles with `err=01`.
  - A `lstm_valid` pulse in IDLE gives `err=11`.
  - `err_clr` gives 00.
- **Reset mid-step, and contention.**
  - Drop `rst_n` in WAIT: all outputs go to 0 asynchronously, and after release the next sample works normally.
  - Assert `cfg_valid` and `s_x_valid` together: the config is taken first.
